// File: rtl/mfp_irq_pkg.sv
// Shared constants for the MFP interrupt controller: register map, channel count, VR bits.
// Optional daisy-chain ports are enabled by defining MFP_IRQ_DAISY_EN.
package mfp_irq_pkg;

   localparam int NUM_CH   = 16;
   localparam int VR_S_BIT = 3;

   localparam logic [3:0] ADDR_IERA = 4'd0;
   localparam logic [3:0] ADDR_IERB = 4'd1;
   localparam logic [3:0] ADDR_IPRA = 4'd2;
   localparam logic [3:0] ADDR_IPRB = 4'd3;
   localparam logic [3:0] ADDR_ISRA = 4'd4;
   localparam logic [3:0] ADDR_ISRB = 4'd5;
   localparam logic [3:0] ADDR_IMRA = 4'd6;
   localparam logic [3:0] ADDR_IMRB = 4'd7;
   localparam logic [3:0] ADDR_VR   = 4'd8;

endpackage

// File: rtl/mfp_prio_enc.sv
// Masked priority encoder: reports the highest channel with req & mask set.
module mfp_prio_enc
   import mfp_irq_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0] mask,
   output logic              valid,
   output logic [3:0]        index
);

   logic [NUM_CH-1:0] hits;

   assign hits = req & mask;

   // Ascending scan so the highest set channel is the last one assigned.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (hits[i]) begin
            valid = 1'b1;
            index = 4'(i);
         end
      end
   end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// MFP-style 16-channel interrupt controller with IER/IPR/ISR/IMR/VR registers and vectored acknowledge.
// Define MFP_IRQ_DAISY_EN to add the IEI_N/IEO_N daisy-chain ports.
module mfp_irq_ctrl
   import mfp_irq_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [NUM_CH-1:0] IRQ_IN,
   input  logic              WE,
   input  logic [3:0]        ADDR,
   input  logic [7:0]        DAT_I,
   output logic [7:0]        DAT_O,
   input  logic              IACK,
   output logic              IRQ_N,
   output logic [7:0]        VEC_O,
`ifdef MFP_IRQ_DAISY_EN
   output logic              VEC_VALID,
   input  logic              IEI_N,
   output logic              IEO_N
`else
   output logic              VEC_VALID
`endif
);

   logic [NUM_CH-1:0] ier, ipr, isr, imr;
   logic [7:0]        vr;
   logic [NUM_CH-1:0] ier_nx, ipr_nx, isr_nx, imr_nx;
   logic [7:0]        vr_nx;
   logic [NUM_CH-1:0] ipr_clr, isr_clr;
   logic [NUM_CH-1:0] above_isr, elig;
   logic              isr_blocked;
   logic              s_bit;
   logic              cand_valid;
   logic [3:0]        cand_idx;
   logic              iei_n_eff;
   logic              ack_hit;
   logic [NUM_CH-1:0] ack_onehot;

`ifdef MFP_IRQ_DAISY_EN
   assign iei_n_eff = IEI_N;
   assign IEO_N     = IEI_N | cand_valid;
`else
   assign iei_n_eff = 1'b0;
`endif

   assign s_bit = vr[VR_S_BIT];

   // In software-EOI mode a channel is eligible only above the highest in-service channel.
   always_comb begin
      isr_blocked = 1'b0;
      above_isr   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         isr_blocked  = isr_blocked | isr[i];
         above_isr[i] = ~isr_blocked;
      end
      elig = s_bit ? (imr & above_isr) : imr;
   end

   mfp_prio_enc u_prio_enc (
      .req   (ipr),
      .mask  (elig),
      .valid (cand_valid),
      .index (cand_idx)
   );

   assign ack_hit    = IACK & ~iei_n_eff & cand_valid;
   assign ack_onehot = ack_hit ? (16'd1 << cand_idx) : '0;

   always_comb begin
      ier_nx  = ier;
      imr_nx  = imr;
      vr_nx   = vr;
      ipr_clr = ack_onehot;
      isr_clr = '0;
      if (WE) begin
         case (ADDR)
            ADDR_IERA: begin ier_nx[15:8] = DAT_I; ipr_clr[15:8] = ipr_clr[15:8] | ~DAT_I; end
            ADDR_IERB: begin ier_nx[7:0]  = DAT_I; ipr_clr[7:0]  = ipr_clr[7:0]  | ~DAT_I; end
            ADDR_IPRA: ipr_clr[15:8] = ipr_clr[15:8] | ~DAT_I;
            ADDR_IPRB: ipr_clr[7:0]  = ipr_clr[7:0]  | ~DAT_I;
            ADDR_ISRA: isr_clr[15:8] = ~DAT_I;
            ADDR_ISRB: isr_clr[7:0]  = ~DAT_I;
            ADDR_IMRA: imr_nx[15:8]  = DAT_I;
            ADDR_IMRB: imr_nx[7:0]   = DAT_I;
            ADDR_VR:   vr_nx         = DAT_I;
            default: ;
         endcase
      end
      // A new event wins over any clear of the same pending bit in this cycle.
      ipr_nx = (ipr & ~ipr_clr) | (IRQ_IN & ier);
      isr_nx = isr & ~isr_clr;
      if (s_bit) isr_nx = isr_nx | ack_onehot;
      if (!vr_nx[VR_S_BIT]) isr_nx = '0;
   end

   // VEC_VALID is a one-cycle qualifier for VEC_O with no back-pressure:
   // VEC_O is meaningful only in the cycle VEC_VALID is high.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ier       <= '0;
         ipr       <= '0;
         isr       <= '0;
         imr       <= '0;
         vr        <= '0;
         IRQ_N     <= 1'b1;
         VEC_O     <= '0;
         VEC_VALID <= 1'b0;
      end else begin
         ier       <= ier_nx;
         ipr       <= ipr_nx;
         isr       <= isr_nx;
         imr       <= imr_nx;
         vr        <= vr_nx;
         IRQ_N     <= ~cand_valid;
         VEC_VALID <= ack_hit;
         if (ack_hit) VEC_O <= {vr[7:4], cand_idx};
      end
   end

   always_comb begin
      case (ADDR)
         ADDR_IERA: DAT_O = ier[15:8];
         ADDR_IERB: DAT_O = ier[7:0];
         ADDR_IPRA: DAT_O = ipr[15:8];
         ADDR_IPRB: DAT_O = ipr[7:0];
         ADDR_ISRA: DAT_O = isr[15:8];
         ADDR_ISRB: DAT_O = isr[7:0];
         ADDR_IMRA: DAT_O = imr[15:8];
         ADDR_IMRB: DAT_O = imr[7:0];
         ADDR_VR:   DAT_O = vr;
         default:   DAT_O = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Self-checking bench for mfp_irq_ctrl: directed scenarios plus random traffic,
// checked against a behavioural model with a vector scoreboard.
module tb_mfp_irq_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [15:0] IRQ_IN = '0;
   logic        WE = 1'b0;
   logic [3:0]  ADDR = '0;
   logic [7:0]  DAT_I = '0;
   logic [7:0]  DAT_O;
   logic        IACK = 1'b0;
   logic        IRQ_N;
   logic [7:0]  VEC_O;
   logic        VEC_VALID;
`ifdef MFP_IRQ_DAISY_EN
   logic        IEI_N = 1'b0;
   logic        IEO_N;
`endif

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   // Behavioural model state
   logic [15:0] m_ier = '0, m_ipr = '0, m_isr = '0, m_imr = '0;
   logic [7:0]  m_vr = '0;
   logic        m_irq_n = 1'b1;
   logic        m_vec_valid = 1'b0;
   logic [7:0]  exp_q[$];

   mfp_irq_ctrl dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IRQ_IN    (IRQ_IN),
      .WE        (WE),
      .ADDR      (ADDR),
      .DAT_I     (DAT_I),
      .DAT_O     (DAT_O),
      .IACK      (IACK),
      .IRQ_N     (IRQ_N),
      .VEC_O     (VEC_O),
`ifdef MFP_IRQ_DAISY_EN
      .VEC_VALID (VEC_VALID),
      .IEI_N     (IEI_N),
      .IEO_N     (IEO_N)
`else
      .VEC_VALID (VEC_VALID)
`endif
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Highest pending, unmasked channel; with S set it must outrank every in-service channel.
   function automatic int model_cand();
      int top_isr = -1;
      for (int i = 0; i < 16; i++) if (m_isr[i]) top_isr = i;
      for (int n = 15; n >= 0; n--)
         if (m_ipr[n] && m_imr[n] && (!m_vr[3] || n > top_isr)) return n;
      return -1;
   endfunction

   function automatic logic [7:0] model_read(input logic [3:0] a);
      case (a)
         4'd0: return m_ier[15:8];
         4'd1: return m_ier[7:0];
         4'd2: return m_ipr[15:8];
         4'd3: return m_ipr[7:0];
         4'd4: return m_isr[15:8];
         4'd5: return m_isr[7:0];
         4'd6: return m_imr[15:8];
         4'd7: return m_imr[7:0];
         4'd8: return m_vr;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_step(input logic rst, input logic [15:0] irq, input logic we,
                             input logic [3:0] a, input logic [7:0] d, input logic iack);
      int c;
      logic [15:0] n_ier, n_ipr, n_isr, n_imr;
      logic [7:0]  n_vr;
      if (!rst) begin
         m_ier = '0; m_ipr = '0; m_isr = '0; m_imr = '0; m_vr = '0;
         m_irq_n = 1'b1; m_vec_valid = 1'b0;
         return;
      end
      c = model_cand();
      n_ier = m_ier; n_imr = m_imr; n_vr = m_vr; n_ipr = m_ipr; n_isr = m_isr;
      if (iack && c >= 0) exp_q.push_back({m_vr[7:4], 4'(c)});
      m_vec_valid = iack && c >= 0;
      m_irq_n = (c < 0);
      for (int n = 0; n < 16; n++) begin
         int  byte_sel = (n >= 8) ? 0 : 1;
         logic dbit    = d[n % 8];
         logic wr_here = we && (a[0] == byte_sel[0]);
         if (wr_here && a == 4'(0 + byte_sel)) begin n_ier[n] = dbit; if (!dbit) n_ipr[n] = 1'b0; end
         if (wr_here && a == 4'(2 + byte_sel) && !dbit) n_ipr[n] = 1'b0;
         if (wr_here && a == 4'(4 + byte_sel) && !dbit) n_isr[n] = 1'b0;
         if (wr_here && a == 4'(6 + byte_sel)) n_imr[n] = dbit;
         if (iack && n == c) begin
            n_ipr[n] = 1'b0;
            if (m_vr[3]) n_isr[n] = 1'b1;
         end
         if (irq[n] && m_ier[n]) n_ipr[n] = 1'b1;
      end
      if (we && a == 4'd8) n_vr = d;
      if (!n_vr[3]) n_isr = '0;
      m_ier = n_ier; m_ipr = n_ipr; m_isr = n_isr; m_imr = n_imr; m_vr = n_vr;
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic rst, input logic [15:0] irq, input logic we, input logic [3:0] a,
                       input logic [7:0] d, input logic iack, input logic do_exp = 1'b0,
                       input logic [7:0] exp_dat = 8'h00);
      @(negedge CLK);
      #1;
      RST_N = rst; IRQ_IN = irq; WE = we; ADDR = a; DAT_I = d; IACK = iack;
      #1;
      if (mon_en) chk("dat_o_model", 16'(DAT_O), 16'(model_read(a)));
      if (do_exp) chk($sformatf("reg%0d", a), 16'(DAT_O), 16'(exp_dat));
      model_step(rst, irq, we, a, d, iack);
   endtask

   task automatic idle();                          step(1'b1, '0, 1'b0, 4'd0, 8'h00, 1'b0); endtask
   task automatic do_reset();                      step(1'b0, '0, 1'b0, 4'd0, 8'h00, 1'b0); endtask
   task automatic wr(input logic [3:0] a, input logic [7:0] d); step(1'b1, '0, 1'b1, a, d, 1'b0); endtask
   task automatic pulse(input logic [15:0] irq);   step(1'b1, irq, 1'b0, 4'd0, 8'h00, 1'b0); endtask
   task automatic rd(input logic [3:0] a, input logic [7:0] e); step(1'b1, '0, 1'b0, a, 8'h00, 1'b0, 1'b1, e); endtask

   task automatic ack_expect(input logic [7:0] v);
      step(1'b1, '0, 1'b0, 4'd0, 8'h00, 1'b1);
      @(posedge CLK); #1;
      chk("ack_vec_valid", 16'(VEC_VALID), 16'd1);
      chk("ack_vec_o", 16'(VEC_O), 16'(v));
   endtask

   task automatic irq_n_after_edge(input string name, input logic e);
      @(posedge CLK); #1;
      chk(name, 16'(IRQ_N), 16'(e));
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge CLK) begin
      if (mon_en) begin
         chk("irq_n", 16'(IRQ_N), 16'(m_irq_n));
         chk("vec_valid", 16'(VEC_VALID), 16'(m_vec_valid));
         if (m_vec_valid) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (VEC_VALID) chk("vec_o", 16'(VEC_O), 16'(e));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      do_reset();
      @(posedge CLK); #1;
      mon_en = 1'b1;

      // Reset values
      for (int a = 0; a <= 8; a++) rd(4'(a), 8'h00);
      chk("reset_irq_n", 16'(IRQ_N), 16'd1);
      chk("reset_vec_valid", 16'(VEC_VALID), 16'd0);

      // Basic vectored acknowledge on channel 13
      wr(4'd0, 8'h20); wr(4'd6, 8'h20); wr(4'd8, 8'h40);
      pulse(16'h2000);
      rd(4'd2, 8'h20);
      @(posedge CLK); #1; chk("irq_n_low", 16'(IRQ_N), 16'd0);
      ack_expect(8'h4D);
      rd(4'd2, 8'h00);
      irq_n_after_edge("irq_n_high_after_ack", 1'b1);

      // Software EOI: in-service channel 13 blocks channel 8 until ISR is cleared
      do_reset();
      wr(4'd8, 8'h48); wr(4'd0, 8'h21); wr(4'd6, 8'h21);
      pulse(16'h2000);
      ack_expect(8'h4D);
      pulse(16'h0100);
      idle();
      irq_n_after_edge("irq_n_blocked_by_isr", 1'b1);
      rd(4'd4, 8'h20);
      wr(4'd4, 8'hDF);
      irq_n_after_edge("irq_n_same_cycle_eoi", 1'b1);
      idle();
      irq_n_after_edge("irq_n_low_after_eoi", 1'b0);
      ack_expect(8'h48);
      rd(4'd4, 8'h01);
      wr(4'd8, 8'h40);
      rd(4'd4, 8'h00);

      // Two simultaneous events served in priority order
      do_reset();
      wr(4'd0, 8'h10); wr(4'd1, 8'h20); wr(4'd6, 8'h10); wr(4'd7, 8'h20); wr(4'd8, 8'h40);
      pulse(16'h1020);
      ack_expect(8'h4C);
      ack_expect(8'h45);

      // Event beats a same-cycle clear of its pending bit
      do_reset();
      wr(4'd1, 8'h01);
      pulse(16'h0001);
      step(1'b1, 16'h0001, 1'b1, 4'd3, 8'hFE, 1'b0);
      rd(4'd3, 8'h01);
      wr(4'd3, 8'hFE);
      rd(4'd3, 8'h00);

      // Masked channel: acknowledge returns nothing and leaves pending state alone
      do_reset();
      wr(4'd1, 8'h01);
      pulse(16'h0001);
      step(1'b1, '0, 1'b0, 4'd0, 8'h00, 1'b1);
      @(posedge CLK); #1; chk("masked_no_vec", 16'(VEC_VALID), 16'd0);
      rd(4'd3, 8'h01);
      chk("masked_irq_n", 16'(IRQ_N), 16'd1);

      // Reset during acknowledge aborts it
      do_reset();
      wr(4'd1, 8'h01); wr(4'd7, 8'h01); wr(4'd8, 8'h40);
      pulse(16'h0001);
      idle();
      step(1'b0, 16'h0001, 1'b1, 4'd8, 8'h48, 1'b1);
      @(posedge CLK); #1;
      chk("rst_ack_vec_valid", 16'(VEC_VALID), 16'd0);
      chk("rst_ack_irq_n", 16'(IRQ_N), 16'd1);
      chk("rst_ack_vec_o", 16'(VEC_O), 16'd0);
      for (int a = 0; a <= 8; a++) rd(4'(a), 8'h00);
      rd(4'd12, 8'h00);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         logic        r_rst, r_we, r_iack;
         logic [15:0] r_irq;
         logic [3:0]  r_a;
         logic [7:0]  r_d;
         r_rst = ($urandom_range(0, 149) != 0);
         r_irq = '0;
         for (int b = 0; b < 16; b++) r_irq[b] = ($urandom_range(0, 7) == 0);
         r_we   = ($urandom_range(0, 4) == 0);
         r_a    = 4'($urandom_range(0, 11));
         r_d    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
         if (r_a == 4'd8) r_d = {4'($urandom), ($urandom_range(0, 1) == 0), 3'($urandom)};
         r_iack = ($urandom_range(0, 3) == 0);
         step(r_rst, r_irq, r_we, r_a, r_d, r_iack);
      end
      idle();
      idle();

      chk("exp_q_empty", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mfp_irq_ctrl.md
MFP_IRQ_CTRL -- requirements
Module: mfp_irq_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port IRQ_IN, input, 16 bits: single-cycle event pulses, one per channel (timer T_O_PULSE, GPIP edges, USART); channel 15 highest priority.
REQ-004 SHALL have port WE, input, 1 bit: register write strobe.
REQ-005 SHALL have port ADDR, input, 4 bits: register select.
REQ-006 SHALL have port DAT_I, input, 8 bits: write data.
REQ-007 SHALL have port DAT_O, output, 8 bits: read data for ADDR, combinational.
REQ-008 SHALL have port IACK, input, 1 bit: single-cycle interrupt-acknowledge strobe.
REQ-009 SHALL have port IRQ_N, output, 1 bit: registered active-low interrupt request.
REQ-010 SHALL have port VEC_O, output, 8 bits: acknowledged vector.
REQ-011 SHALL have port VEC_VALID, output, 1 bit: one-cycle qualifier for VEC_O.

Function
REQ-012 SHALL decode ADDR as 0 IERA, 1 IERB, 2 IPRA, 3 IPRB, 4 ISRA, 5 ISRB, 6 IMRA, 7 IMRB, 8 VR; A = channels 15:8, B = channels 7:0; other addresses read 0x00 and ignore writes.
REQ-013 SHALL set IPR[n] on IRQ_IN[n] only when IER[n]=1.
REQ-014 SHALL clear IPR[n] in the same cycle that a write sets IER[n]=0.
REQ-015 SHALL treat IPR and ISR writes as clear-only: a 0 bit clears, a 1 bit leaves the bit unchanged.
REQ-016 SHALL let IMR gate only IRQ_N and acknowledge selection; pending bits persist while masked.
REQ-017 SHALL define the candidate as the highest n with IPR[n]&IMR[n]=1; when VR[3] (S, software-EOI) is 1, the candidate also requires n greater than the highest set ISR bit.
REQ-018 SHALL drive IRQ_N low exactly one cycle after a candidate exists, and high one cycle after none exists.
REQ-019 SHALL, on IACK with candidate n: clear IPR[n]; set ISR[n] if S=1; on the next cycle drive VEC_O={VR[7:4],n[3:0]} with VEC_VALID=1 for one cycle.
REQ-020 SHALL, on IACK with no candidate, leave all state unchanged and keep VEC_VALID=0.
REQ-021 SHALL latch the candidate at the IACK cycle; later IRQ_IN pulses do not alter the returned vector.
REQ-022 SHALL give IRQ_IN set priority over a same-cycle register clear or IACK clear of the same IPR bit.
REQ-023 SHALL clear all ISR bits when VR is written with S=0.
REQ-024 SHALL hold ISR at zero while S=0.

Reset
REQ-025 SHALL, with RST_N low at a CLK edge, clear all of IER, IPR, ISR, IMR and VR, drive IRQ_N=1, VEC_VALID=0 and VEC_O=0x00.
REQ-026 SHALL treat reset as taking precedence over simultaneous WE, IACK or IRQ_IN in the same cycle.
REQ-027 SHALL abort an IACK in progress on reset; VEC_VALID stays 0.

Configuration
REQ-028 SHALL, with MFP_IRQ_DAISY_EN defined, add input IEI_N and output IEO_N.
REQ-029 SHALL, with MFP_IRQ_DAISY_EN defined, ignore IACK while IEI_N=1 and drive IEO_N low only when IEI_N=0 and there is no candidate.
REQ-030 SHALL, without MFP_IRQ_DAISY_EN, omit IEI_N and IEO_N and behave as if IEI_N=0.

Structure
REQ-031 SHALL place the register address constants, the channel count (16) and the VR S-bit index in shared package mfp_irq_pkg.
REQ-032 SHALL implement candidate selection in sub-module mfp_prio_enc: a 16-bit masked priority encoder producing a valid flag and a 4-bit index.

Verification
REQ-033 SHALL cover: IERA=0x20, IMRA=0x20, IRQ_IN[13] pulse -> IPRA=0x20, IRQ_N low after one cycle; IACK with VR=0x40 -> VEC_O=0x4D, VEC_VALID pulse, IPRA=0x00, IRQ_N high.
REQ-034 SHALL cover: S=1, ISRA bit 13 set, IRQ_IN[8] pending and unmasked -> IRQ_N stays high; write ISRA=0xDF -> IRQ_N low after one cycle.
REQ-035 SHALL cover: IRQ_IN[5] and IRQ_IN[12] in the same cycle, both enabled and unmasked -> first IACK returns n=12, second returns n=5.
REQ-036 SHALL cover: IPRB write 0xFE in the same cycle as IRQ_IN[0] -> IPRB bit 0 remains 1.
REQ-037 SHALL cover: IMR=0, channel pending, IACK -> VEC_VALID stays 0 and IPR is unchanged.
REQ-038 SHALL cover: RST_N low during the IACK cycle -> all registers 0x00, IRQ_N=1, no VEC_VALID pulse.
